// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters.
// Grants in IDLE, gives the ALU one settle cycle in EXEC, and holds a tagged response in RESP.
module alu_arbiter #(
  parameter int n    = 32,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*n-1:0] req_a,
  input  logic [NREQ*n-1:0] req_b,
  input  logic [NREQ*3-1:0] req_ctr,
  output logic [n-1:0]      alu_a,
  output logic [n-1:0]      alu_b,
  output logic [2:0]        alu_ctr,
  input  logic [n-1:0]      alu_result,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [n-1:0]      resp_result,
  output logic              resp_zero,
  output logic              resp_overflow,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_reg;
  logic [IDW-1:0]   grant_reg;
  logic [IDW-1:0]   last_grant_reg;
  logic [n-1:0]     alu_a_reg;
  logic [n-1:0]     alu_b_reg;
  logic [2:0]       alu_ctr_reg;
  logic [IDW-1:0]   resp_id_reg;
  logic [n-1:0]     resp_result_reg;
  logic             resp_zero_reg;
  logic             resp_overflow_reg;

  logic [n-1:0]     a_arr   [NREQ];
  logic [n-1:0]     b_arr   [NREQ];
  logic [2:0]       ctr_arr [NREQ];

  logic             win_found;
  logic [IDW-1:0]   win_idx;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi]   = req_a[gi*n +: n];
      assign b_arr[gi]   = req_b[gi*n +: n];
      assign ctr_arr[gi] = req_ctr[gi*3 +: 3];
    end
  endgenerate

  // Search starts just past the last completed grant and wraps, so the
  // previous owner is considered last.
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_w;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    idx_w     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx   = (int'(last_grant_reg) + k) % NREQ;
      idx_w = IDW'(idx);
      if (!win_found && req_valid[idx_w]) begin
        win_found = 1'b1;
        win_idx   = idx_w;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state_reg == IDLE && win_found)
      req_ready[win_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      grant_reg         <= '0;
      last_grant_reg    <= IDW'(NREQ - 1);
      alu_a_reg         <= '0;
      alu_b_reg         <= '0;
      alu_ctr_reg       <= '0;
      resp_id_reg       <= '0;
      resp_result_reg   <= '0;
      resp_zero_reg     <= 1'b0;
      resp_overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            alu_a_reg   <= a_arr[win_idx];
            alu_b_reg   <= b_arr[win_idx];
            alu_ctr_reg <= ctr_arr[win_idx];
            grant_reg   <= win_idx;
            state_reg   <= EXEC;
          end
        end
        EXEC: begin
          resp_result_reg   <= alu_result;
          resp_zero_reg     <= alu_zero;
          resp_overflow_reg <= alu_overflow;
          resp_id_reg       <= grant_reg;
          state_reg         <= RESP;
        end
        RESP: begin
          // Pointer moves only on completion, keeping the rotation fair under back-pressure.
          if (resp_ready) begin
            last_grant_reg <= grant_reg;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign alu_a         = alu_a_reg;
  assign alu_b         = alu_b_reg;
  assign alu_ctr       = alu_ctr_reg;
  assign resp_valid    = (state_reg == RESP);
  assign resp_id       = resp_id_reg;
  assign resp_result   = resp_result_reg;
  assign resp_zero     = resp_zero_reg;
  assign resp_overflow = resp_overflow_reg;
  assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with an adder standing in for the ALU.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu_arbiter;

  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ*3-1:0] req_ctr;
  logic [N-1:0]      alu_a;
  logic [N-1:0]      alu_b;
  logic [2:0]        alu_ctr;
  logic [N-1:0]      alu_result;
  logic              alu_zero;
  logic              alu_overflow;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [N-1:0]      resp_result;
  logic              resp_zero;
  logic              resp_overflow;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  alu_arbiter #(.n(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_ctr       (req_ctr),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_ctr       (alu_ctr),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero),
    .alu_overflow  (alu_overflow),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_result   (resp_result),
    .resp_zero     (resp_zero),
    .resp_overflow (resp_overflow),
    .busy          (busy)
  );

  // ALU stand-in: add with signed-overflow detection.
  assign alu_result   = alu_a + alu_b;
  assign alu_zero     = (alu_result == '0);
  assign alu_overflow = (alu_a[N-1] == alu_b[N-1]) && (alu_result[N-1] != alu_a[N-1]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b);
    req_a[id*N +: N]   = a;
    req_b[id*N +: N]   = b;
    req_ctr[id*3 +: 3] = 3'b010;
  endtask

  // Called at a falling edge with the DUT in IDLE; returns at a falling edge in IDLE.
  task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic exp_z, input logic exp_o);
    set_req(id, a, b);
    req_valid = 4'(1 << id);
    #1 check("op_ready", req_ready, 64'(1 << id));
    @(negedge clk);
    req_valid = '0;
    check("op_exec_busy", busy, 1);
    check("op_alu_a", alu_a, a);
    check("op_alu_b", alu_b, b);
    @(negedge clk);
    check("op_resp_valid", resp_valid, 1);
    check("op_resp_id", resp_id, 64'(id));
    check("op_result", resp_result, exp_r);
    check("op_zero", resp_zero, exp_z);
    check("op_ovf", resp_overflow, exp_o);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("op_idle_busy", busy, 0);
    check("op_idle_rv", resp_valid, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_ctr    = '0;
    resp_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_ctr", alu_ctr, 0);
    check("rst_resp_result", resp_result, 0);
    check("rst_resp_id", resp_id, 0);
    rst_n = 1'b1;

    // Single op and flag cases
    run_op(0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    run_op(2, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1);
    run_op(2, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b1, 1'b0);

    // Round-robin with everyone valid from reset
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(100 * (i + 1)), 32'(i));
    req_valid  = '1;
    resp_ready = 1'b1;
    rst_n      = 1'b1;
    for (int g = 0; g < 5; g++) begin
      #1 check("rr_grant", req_ready, 64'(1 << (g % NREQ)));
      @(negedge clk);
      check("rr_exec_ready", req_ready, 0);
      @(negedge clk);
      check("rr_resp_id", resp_id, 64'(g % NREQ));
      check("rr_result", resp_result, 64'(100 * ((g % NREQ) + 1) + (g % NREQ)));
      @(negedge clk);
    end

    // Back-pressure: last_grant is 0, so requester 1 is next
    resp_ready = 1'b0;
    #1 check("bp_grant", req_ready, 64'b0010);
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      check("bp_resp_valid", resp_valid, 1);
      check("bp_resp_id", resp_id, 1);
      check("bp_result", resp_result, 64'd201);
      check("bp_busy", busy, 1);
      check("bp_req_ready", req_ready, 0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("bp_release_busy", busy, 0);
    check("bp_next_grant", req_ready, 64'b0100);
    req_valid = '0;
    @(negedge clk);

    // Wrap search: make last_grant 3, then only 1 and 3 valid
    run_op(3, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0);
    set_req(1, 32'd1000, 32'd1);
    set_req(3, 32'd3000, 32'd3);
    req_valid  = 4'b1010;
    resp_ready = 1'b1;
    #1 check("wrap_first", req_ready, 64'b0010);
    @(negedge clk);
    @(negedge clk);
    check("wrap_first_id", resp_id, 1);
    check("wrap_first_res", resp_result, 64'd1001);
    @(negedge clk);
    check("wrap_second", req_ready, 64'b1000);
    @(negedge clk);
    @(negedge clk);
    check("wrap_second_id", resp_id, 3);
    check("wrap_second_res", resp_result, 64'd3003);
    req_valid = '0;
    @(negedge clk);
    resp_ready = 1'b0;

    // Async reset during EXEC, with last_grant moved to 1 beforehand
    run_op(1, 32'd4, 32'd4, 32'd8, 1'b0, 1'b0);
    set_req(0, 32'd1, 32'd2);
    set_req(2, 32'd50, 32'd60);
    req_valid = 4'b0101;
    #1 check("rst_pre_grant", req_ready, 64'b0100);
    @(negedge clk);
    req_valid = '0;
    check("rst_in_exec", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_alu_a", alu_a, 0);
    check("arst_resp_valid", resp_valid, 0);
    check("arst_req_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("arst_no_resp", resp_valid, 0);
    end
    run_op(0, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Never two ready bits at once.
  always @(negedge clk) begin
    if (rst_n && (req_ready & (req_ready - 1'b1)) != '0) begin
      failures++;
      $display("FAIL onehot_ready got=0x%0h expected=onehot_or_zero", req_ready);
    end
  end

endmodule
